// File: rtl/mem_stage.sv
// mem_stage: load/store unit with single-outstanding data bus request, timeout and writeback
module mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  op_type,
  input  logic [4:0]  op_spec,
  input  logic [4:0]  rd_ind,
  input  logic [31:0] rd_dat,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dat,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_we,
  output logic [4:0]  wb_rd_ind,
  output logic [31:0] wb_rd_dat,
  output logic        misalign_exc,
  output logic        bus_err
);
  typedef enum logic {IDLE, REQ} state_t;
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYC - 1);
  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  spec_q;
  logic [1:0]  lo_q;
  logic [4:0]  rd_q;
  logic        is_ld, mem_op, mis, go, done, tmo;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, ld_val;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  // decode the incoming op, lane steering for stores, and load data extraction
  always_comb begin
    is_ld   = op_spec <= 5'd4;
    mem_op  = op_type == 4'b0001 && op_spec <= 5'd7 && (mem_read_en ^ mem_write_en) && (is_ld ? mem_read_en : mem_write_en);
    mis     = ((op_spec == 5'd1 || op_spec == 5'd4 || op_spec == 5'd6) && mem_addr[0]) || ((op_spec == 5'd2 || op_spec == 5'd7) && |mem_addr[1:0]);
    go      = state == IDLE && mem_op && !mis;
    done    = state == REQ && dmem_ack;
    tmo     = state == REQ && !dmem_ack && cnt == LAST;
    stall   = state == REQ ? ~dmem_ack : go;
    be_n    = op_spec == 5'd5 ? 4'b0001 << mem_addr[1:0] : op_spec == 5'd6 ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_n = op_spec == 5'd5 ? {4{mem_dat[7:0]}} : op_spec == 5'd6 ? {2{mem_dat[15:0]}} : mem_dat;
    byte_v  = dmem_rdata[{lo_q, 3'b000} +: 8];
    half_v  = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_val  = spec_q == 3'd0 ? {{24{byte_v[7]}}, byte_v} : spec_q == 3'd1 ? {{16{half_v[15]}}, half_v} : spec_q == 3'd3 ? {24'b0, byte_v} : spec_q == 3'd4 ? {16'b0, half_v} : dmem_rdata;
  end
  // request FSM, bus registers, timeout counter, writeback and exception pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      spec_q       <= '0;
      lo_q         <= '0;
      rd_q         <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      wb_we        <= 1'b0;
      wb_rd_ind    <= '0;
      wb_rd_dat    <= '0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_exc <= state == IDLE && mem_op && mis;
      bus_err      <= tmo;
      if (state == IDLE) begin
        if (go) begin
          state      <= REQ;
          dmem_req   <= 1'b1;
          dmem_we    <= !is_ld;
          dmem_addr  <= {mem_addr[31:2], 2'b00};
          dmem_wdata <= wdata_n;
          dmem_be    <= be_n;
          spec_q     <= op_spec[2:0];
          lo_q       <= mem_addr[1:0];
          rd_q       <= rd_ind;
        end
        if (op_type != 4'b0001) begin
          wb_we     <= |rd_ind && (op_type == 4'd0 || op_type == 4'd3 || op_type == 4'd4);
          wb_rd_ind <= rd_ind;
          wb_rd_dat <= rd_dat;
        end else begin
          wb_we <= 1'b0;
        end
      end else begin
        if (done || tmo) begin
          state    <= IDLE;
          cnt      <= '0;
          dmem_req <= 1'b0;
        end else begin
          cnt <= cnt + 16'd1;
        end
        wb_we <= done && spec_q <= 3'd4 && |rd_q;
        if (done && spec_q <= 3'd4) begin
          wb_rd_ind <= rd_q;
          wb_rd_dat <= ld_val;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage against a lane-level reference model
module tb_mem_stage;
  localparam int T = 4;
  logic        clk = 0, rst_n;
  logic [3:0]  op_type;
  logic [4:0]  op_spec, rd_ind;
  logic [31:0] rd_dat, mem_addr, mem_dat, dmem_addr, dmem_wdata, dmem_rdata, wb_rd_dat;
  logic        mem_read_en, mem_write_en, stall, dmem_req, dmem_we, dmem_ack, wb_we, misalign_exc, bus_err;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_rd_ind;
  int checks = 0, failures = 0;

  mem_stage #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .op_type(op_type), .op_spec(op_spec), .rd_ind(rd_ind), .rd_dat(rd_dat),
    .mem_addr(mem_addr), .mem_dat(mem_dat), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_we(wb_we), .wb_rd_ind(wb_rd_ind),
    .wb_rd_dat(wb_rd_dat), .misalign_exc(misalign_exc), .bus_err(bus_err));

  always #5 clk = ~clk;

  function automatic int acc_size(int s);
    return (s == 0 || s == 3 || s == 5) ? 1 : (s == 1 || s == 4 || s == 6) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_be(int s, logic [31:0] a);
    logic [3:0] r = 0;
    int sz = s <= 4 ? 4 : acc_size(s);
    int base = (int'(a % 4) / sz) * sz;
    for (int i = 0; i < 4; i++) if (i >= base && i < base + sz) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] exp_wdata(int s, logic [31:0] d);
    logic [31:0] w;
    int sz = acc_size(s);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(int s, logic [31:0] a, logic [31:0] rdata);
    int sz = acc_size(s);
    int off = (int'(a % 4) / sz) * sz;
    longint v = (longint'(rdata) >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
    if ((s == 0 || s == 1) && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  task automatic idle_in;
    op_type = 4'b0001; op_spec = 0; mem_read_en = 0; mem_write_en = 0;
    rd_ind = 0; rd_dat = 0; mem_addr = 0; mem_dat = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic run_mem(input int s, input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd, input int delay, input logic [31:0] rdata);
    bit ld = s <= 4;
    bit to = delay > T - 1;
    int last = to ? T - 1 : delay;
    @(negedge clk);
    op_type = 4'b0001; op_spec = 5'(s); mem_addr = a; mem_dat = d; rd_ind = rd;
    mem_read_en = ld; mem_write_en = !ld; dmem_ack = 0;
    #1 checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL stall_issue got=%b exp=1", stall); end
    @(posedge clk); #1;
    checks++;
    if ({dmem_addr, dmem_be, dmem_we} !== {a & 32'hFFFF_FFFC, exp_be(s, a), !ld}) begin
      failures++; $display("FAIL bus_fields spec=%0d got=%h/%b/%b exp=%h/%b/%b", s, dmem_addr, dmem_be, dmem_we, a & 32'hFFFF_FFFC, exp_be(s, a), !ld);
    end
    if (!ld) begin
      checks++;
      if (dmem_wdata !== exp_wdata(s, d)) begin failures++; $display("FAIL wdata spec=%0d got=%h exp=%h", s, dmem_wdata, exp_wdata(s, d)); end
    end
    for (int k = 0; k <= last; k++) begin
      dmem_ack = (k == delay);
      dmem_rdata = (k == delay) ? rdata : $urandom;
      #1 checks++;
      if (dmem_req !== 1'b1 || stall !== !dmem_ack) begin
        failures++; $display("FAIL req_cycle k=%0d got req=%b stall=%b exp req=1 stall=%b", k, dmem_req, stall, !dmem_ack);
      end
      @(posedge clk); #1;
    end
    idle_in;
    checks++;
    if ({dmem_req, bus_err, wb_we} !== {1'b0, to, !to && ld && rd != 0}) begin
      failures++; $display("FAIL completion spec=%0d delay=%0d got req/err/we=%b%b%b exp=0%b%b", s, delay, dmem_req, bus_err, wb_we, to, !to && ld && rd != 0);
    end
    if (!to && ld) begin
      checks++;
      if (wb_rd_dat !== exp_load(s, a, rdata) || wb_rd_ind !== rd) begin
        failures++; $display("FAIL load_data spec=%0d got=%h/%0d exp=%h/%0d", s, wb_rd_dat, wb_rd_ind, exp_load(s, a, rdata), rd);
      end
    end
    @(posedge clk); #1 checks++;
    if ({bus_err, wb_we, stall} !== 3'b000) begin failures++; $display("FAIL after_txn got err/we/stall=%b%b%b exp=000", bus_err, wb_we, stall); end
  endtask

  task automatic test_reset;
    rst_n = 0; idle_in;
    repeat (2) @(posedge clk);
    #1 checks++;
    if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_we, wb_rd_ind, wb_rd_dat, misalign_exc, bus_err} !== '0) begin
      failures++; $display("FAIL reset_values got req=%b we=%b addr=%h be=%b wb=%b/%0d/%h", dmem_req, dmem_we, dmem_addr, dmem_be, wb_we, wb_rd_ind, wb_rd_dat);
    end
    @(negedge clk); rst_n = 1;
    dmem_ack = 1;
    @(posedge clk); #1 checks++;
    if ({dmem_req, wb_we, bus_err, stall} !== 4'b0000) begin failures++; $display("FAIL idle_ack got req/we/err/stall=%b%b%b%b exp=0000", dmem_req, wb_we, bus_err, stall); end
    dmem_ack = 0;
  endtask

  task automatic test_spec_examples;
    run_mem(0, 32'h1003, 0, 5'd7, 3, 32'h80FF_FF00);
    checks++;
    if ({dmem_addr, dmem_be, wb_rd_dat} !== {32'h1000, 4'b1111, 32'hFFFF_FF80}) begin
      failures++; $display("FAIL lb_example got=%h/%b/%h exp=00001000/1111/ffffff80", dmem_addr, dmem_be, wb_rd_dat);
    end
    run_mem(6, 32'h2002, 32'h1234_ABCD, 5'd3, 1, 0);
    checks++;
    if ({dmem_we, dmem_be, dmem_wdata} !== {1'b1, 4'b1100, 32'hABCD_ABCD}) begin
      failures++; $display("FAIL sh_example got=%b/%b/%h exp=1/1100/abcdabcd", dmem_we, dmem_be, dmem_wdata);
    end
  endtask

  task automatic test_misalign;
    int specs [6] = '{2, 1, 4, 6, 7, 7};
    logic [31:0] addrs [6] = '{32'h3001, 32'h11, 32'h23, 32'h45, 32'h56, 32'h7};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      op_type = 4'b0001; op_spec = 5'(specs[i]); mem_addr = addrs[i]; mem_dat = $urandom; rd_ind = 5'd9;
      mem_read_en = specs[i] <= 4; mem_write_en = specs[i] > 4;
      #1 checks++;
      if (stall !== 1'b0) begin failures++; $display("FAIL misalign_stall i=%0d got=%b exp=0", i, stall); end
      @(posedge clk); #1 idle_in;
      checks++;
      if ({misalign_exc, dmem_req, wb_we} !== 3'b100) begin failures++; $display("FAIL misalign_pulse i=%0d got exc/req/we=%b%b%b exp=100", i, misalign_exc, dmem_req, wb_we); end
      @(posedge clk); #1 checks++;
      if (misalign_exc !== 1'b0) begin failures++; $display("FAIL misalign_width i=%0d got=%b exp=0", i, misalign_exc); end
    end
  endtask

  task automatic test_timeout;
    run_mem(4, 32'h0000_4002, 0, 5'd4, 9, 0);
    run_mem(4, 32'h0000_4000, 0, 5'd4, T - 1, 32'h9876_F00D);
    run_mem(7, 32'h0000_5004, 32'hCAFE_0001, 5'd0, 20, 0);
  endtask

  task automatic test_passthrough;
    logic [3:0] ots [2] = '{4'd0, 4'd0};
    logic [4:0] rds [2] = '{5'd5, 5'd0};
    for (int i = 0; i < 14; i++) begin
      logic [3:0] ot = i < 2 ? ots[i] : 4'($urandom_range(0, 15));
      logic [4:0] rd = i < 2 ? rds[i] : 5'($urandom);
      logic [31:0] dv = i < 2 ? 32'hDEAD_BEEF : $urandom;
      if (ot == 4'd1) ot = 4'd3;
      @(negedge clk);
      op_type = ot; rd_ind = rd; rd_dat = dv; op_spec = 5'($urandom); mem_addr = $urandom;
      mem_read_en = 1'($urandom); mem_write_en = 1'($urandom);
      #1 checks++;
      if (stall !== 1'b0) begin failures++; $display("FAIL pass_stall i=%0d got=%b exp=0", i, stall); end
      @(posedge clk); #1 checks++;
      if ({wb_we, wb_rd_ind, wb_rd_dat, dmem_req} !== {rd != 0 && (ot == 0 || ot == 3 || ot == 4), rd, dv, 1'b0}) begin
        failures++; $display("FAIL passthrough i=%0d ot=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, ot, wb_we, wb_rd_ind, wb_rd_dat, rd != 0 && (ot == 0 || ot == 3 || ot == 4), rd, dv);
      end
    end
    idle_in;
    @(posedge clk); #1 checks++;
    if (wb_we !== 1'b0) begin failures++; $display("FAIL no_op_we got=%b exp=0", wb_we); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      int s = $urandom_range(0, 7);
      int sz = acc_size(s);
      logic [31:0] a = $urandom;
      a = sz == 4 ? a & 32'hFFFF_FFFC : sz == 2 ? a & 32'hFFFF_FFFE : a;
      run_mem(s, a, $urandom, 5'($urandom), $urandom_range(0, 5), $urandom);
    end
  endtask

  task automatic test_reset_in_req;
    @(negedge clk);
    op_type = 4'b0001; op_spec = 5'd7; mem_addr = 32'h600; mem_dat = 32'h1111_2222; rd_ind = 5'd2;
    mem_read_en = 0; mem_write_en = 1;
    @(posedge clk); @(posedge clk); #1;
    idle_in; rst_n = 0;
    #1 checks++;
    if ({dmem_req, dmem_we, dmem_be, dmem_addr, stall} !== '0) begin
      failures++; $display("FAIL reset_in_req got req=%b we=%b be=%b addr=%h stall=%b exp all 0", dmem_req, dmem_we, dmem_be, dmem_addr, stall);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1; dmem_ack = 1; dmem_rdata = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 dmem_ack = 0;
      checks++;
      if ({dmem_req, wb_we, misalign_exc, bus_err} !== 4'b0000) begin
        failures++; $display("FAIL post_reset k=%0d got req/we/exc/err=%b%b%b%b exp=0000", k, dmem_req, wb_we, misalign_exc, bus_err);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) run_mem(i % 2 ? 2 : 5, 32'h8000 + 32'(4 * i + (i % 2 ? 0 : i % 4)), $urandom, 5'(i + 1), i % 2 ? 0 : 2, $urandom);
  endtask

  initial begin
    test_reset;
    test_spec_examples;
    test_misalign;
    test_timeout;
    test_passthrough;
    test_back_to_back;
    test_random;
    test_reset_in_req;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
